// File: rtl/factor_game_pkg.sv
// factor_game_pkg
// Shared definitions for the per-player factorization game controller:
//   - 4-bit game state encodings (also decoded by the ready stage)
//   - prime key bit positions and one-hot key codes
//   - question-number to composite-target table
package factor_game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_PLAY = 4'b0010,
    ST_DRAW = 4'b0110,
    ST_GOOD = 4'b1000,
    ST_OUCH = 4'b1001,
    ST_WIN  = 4'b1010,
    ST_LOSE = 4'b1011
  } state_e;

  // KEY bit positions for each prime
  localparam int KEY_BIT_2 = 0;
  localparam int KEY_BIT_3 = 1;
  localparam int KEY_BIT_5 = 2;
  localparam int KEY_BIT_7 = 3;

  localparam logic [3:0] KEY_P2 = 4'(1 << KEY_BIT_2);
  localparam logic [3:0] KEY_P3 = 4'(1 << KEY_BIT_3);
  localparam logic [3:0] KEY_P5 = 4'(1 << KEY_BIT_5);
  localparam logic [3:0] KEY_P7 = 4'(1 << KEY_BIT_7);

  localparam logic [3:0] NUM_MIN = 4'd1;
  localparam logic [3:0] NUM_MAX = 4'd10;

  // Composite target for a question number; 0 for out-of-range numbers.
  function automatic logic [7:0] target_of(input logic [3:0] num);
    logic [7:0] t;
    case (num)
      4'd1:    t = 8'd12;
      4'd2:    t = 8'd18;
      4'd3:    t = 8'd20;
      4'd4:    t = 8'd30;
      4'd5:    t = 8'd42;
      4'd6:    t = 8'd60;
      4'd7:    t = 8'd84;
      4'd8:    t = 8'd90;
      4'd9:    t = 8'd105;
      4'd10:   t = 8'd210;
      default: t = 8'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/factor_game_ctrl_step.sv
// factor_step
// Combinational evaluation of one prime key press against the current target.
// Ports:
//   i_target   [7:0]  current remaining value
//   i_key      [3:0]  one-hot prime key {7,5,3,2}
//   o_correct         key is one-hot and its prime divides i_target
//   o_quotient [7:0]  i_target / p (valid when o_correct)
//   o_finish          correct key whose quotient is 1
module factor_step
  import factor_game_pkg::*;
(
  input  logic [7:0] i_target,
  input  logic [3:0] i_key,
  output logic       o_correct,
  output logic [7:0] o_quotient,
  output logic       o_finish
);

  logic [7:0] w_q2, w_q3, w_q5, w_q7;

  // Constant divisors only; divisibility checked by multiplying back.
  // Products stay within 8 bits since each quotient is floor(target/p).
  assign w_q2 = i_target / 8'd2;
  assign w_q3 = i_target / 8'd3;
  assign w_q5 = i_target / 8'd5;
  assign w_q7 = i_target / 8'd7;

  always_comb begin
    o_correct  = 1'b0;
    o_quotient = 8'd0;
    case (i_key)
      KEY_P2: begin
        o_quotient = w_q2;
        o_correct  = (w_q2 * 8'd2) == i_target;
      end
      KEY_P3: begin
        o_quotient = w_q3;
        o_correct  = (w_q3 * 8'd3) == i_target;
      end
      KEY_P5: begin
        o_quotient = w_q5;
        o_correct  = (w_q5 * 8'd5) == i_target;
      end
      KEY_P7: begin
        o_quotient = w_q7;
        o_correct  = (w_q7 * 8'd7) == i_target;
      end
      default: begin
        o_correct  = 1'b0;
        o_quotient = 8'd0;
      end
    endcase
  end

  assign o_finish = o_correct && (o_quotient == 8'd1);

endmodule

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl
// Per-player controller for the two-player factorization game. Loads a
// composite target on round start, lets the player strip prime factors,
// arbitrates against the opponent's DONE, and keeps the match score.
// Optional macro: FACTOR_GAME_TIMEOUT_EN adds a round timer that ends an
// idle PLAY as a DRAW after ROUND_SEC seconds of TICK_CYC cycles each.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   OK, NUM[3:0]      round-start pulse and question number (1..10)
//   KEY[3:0]          one-hot prime key pulses {7,5,3,2}
//   OPP_DONE          opponent finished this cycle
//   STATE[3:0]        game state code
//   TARGET[7:0]       remaining value
//   SCORE, OPP_SCORE  own / opponent points (saturate at WIN_SCORE)
//   DONE              one-cycle pulse when own remainder reaches 1
//
// state | meaning
// IDLE  | waiting for OK with a valid question number
// PLAY  | player factoring the target
// DRAW  | both finished together (or round timed out), held RESULT_CYC
// GOOD  | player finished first, point scored, held RESULT_CYC
// OUCH  | wrong key or opponent finished first, held RESULT_CYC
// WIN   | own score reached WIN_SCORE, held until RST
// LOSE  | opponent score reached WIN_SCORE, held until RST
module factor_game_ctrl
  import factor_game_pkg::*;
#(
  parameter int unsigned RESULT_CYC = 100_000_000,
  parameter int unsigned TICK_CYC   = 50_000_000,
  parameter int unsigned ROUND_SEC  = 10,
  parameter int unsigned WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic [3:0] KEY,
  input  logic       OPP_DONE,
  output logic [3:0] STATE,
  output logic [7:0] TARGET,
  output logic [3:0] SCORE,
  output logic [3:0] OPP_SCORE,
  output logic       DONE
);

  if (RESULT_CYC < 1 || TICK_CYC < 1 || ROUND_SEC < 1 ||
      WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_param
    $error("factor_game_ctrl: parameter out of range");
  end

  localparam int RCW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
  localparam logic [RCW-1:0] RES_LOAD = RCW'(RESULT_CYC - 1);
  localparam logic [3:0]     WIN_PTS  = 4'(WIN_SCORE);

  state_e         r_state;
  logic [7:0]     r_target;
  logic [3:0]     r_score;
  logic [3:0]     r_opp;
  logic           r_done;
  logic [RCW-1:0] r_res_cnt;

  logic       w_correct;
  logic [7:0] w_quot;
  logic       w_finish;
  logic       w_num_ok;
  logic       w_wrong;

  factor_step u_step (
    .i_target   (r_target),
    .i_key      (KEY),
    .o_correct  (w_correct),
    .o_quotient (w_quot),
    .o_finish   (w_finish)
  );

  assign w_num_ok = (NUM >= NUM_MIN) && (NUM <= NUM_MAX);
  assign w_wrong  = (KEY != 4'd0) && !w_correct;

`ifdef FACTOR_GAME_TIMEOUT_EN
  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int SW = (ROUND_SEC > 1) ? $clog2(ROUND_SEC) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_CYC - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(ROUND_SEC - 1);

  logic [TW-1:0] r_tick;
  logic [SW-1:0] r_sec;
  logic          w_timeout;

  // Last cycle of the last second.
  assign w_timeout = (r_tick == '0) && (r_sec == SEC_LAST);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_target  <= 8'd0;
      r_score   <= 4'd0;
      r_opp     <= 4'd0;
      r_done    <= 1'b0;
      r_res_cnt <= '0;
`ifdef FACTOR_GAME_TIMEOUT_EN
      r_tick    <= '0;
      r_sec     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (OK && w_num_ok) begin
            r_state  <= ST_PLAY;
            r_target <= target_of(NUM);
`ifdef FACTOR_GAME_TIMEOUT_EN
            r_tick   <= TICK_LOAD;
            r_sec    <= '0;
`endif
          end
        end

        ST_PLAY: begin
          // finishing key > OPP_DONE > wrong key > plain correct key > timeout
          if (w_finish) begin
            r_target  <= w_quot;
            r_done    <= 1'b1;
            r_res_cnt <= RES_LOAD;
            if (OPP_DONE) begin
              r_state <= ST_DRAW;
            end else begin
              r_state <= ST_GOOD;
              if (r_score != WIN_PTS) r_score <= r_score + 4'd1;
            end
          end else if (OPP_DONE || w_wrong) begin
            // A wrong key coinciding with OPP_DONE is one point, not two.
            r_state   <= ST_OUCH;
            r_res_cnt <= RES_LOAD;
            if (r_opp != WIN_PTS) r_opp <= r_opp + 4'd1;
          end else if (KEY != 4'd0) begin
            r_target <= w_quot;
          end
`ifdef FACTOR_GAME_TIMEOUT_EN
          else if (w_timeout) begin
            r_state   <= ST_DRAW;
            r_res_cnt <= RES_LOAD;
          end
          if (r_tick == '0) begin
            r_tick <= TICK_LOAD;
            r_sec  <= r_sec + 1'b1;
          end else begin
            r_tick <= r_tick - 1'b1;
          end
`endif
        end

        ST_DRAW, ST_GOOD, ST_OUCH: begin
          if (r_res_cnt == '0) begin
            if (r_score == WIN_PTS) begin
              r_state <= ST_WIN;
            end else if (r_opp == WIN_PTS) begin
              r_state <= ST_LOSE;
            end else begin
              r_state  <= ST_IDLE;
              r_target <= 8'd0;
            end
          end else begin
            r_res_cnt <= r_res_cnt - 1'b1;
          end
        end

        ST_WIN, ST_LOSE: begin
          r_state <= r_state;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_target <= 8'd0;
        end
      endcase
    end
  end

  assign STATE     = r_state;
  assign TARGET    = r_target;
  assign SCORE     = r_score;
  assign OPP_SCORE = r_opp;
  assign DONE      = r_done;

endmodule

// File: tb/tb_factor_game_ctrl.sv
module tb_factor_game_ctrl;
  import factor_game_pkg::*;

  localparam int R  = 8;
  localparam int TK = 4;
  localparam int RS = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       OK = 1'b0;
  logic [3:0] NUM = 4'd0;
  logic [3:0] KEY = 4'd0;
  logic       OPP_DONE = 1'b0;
  logic [3:0] STATE;
  logic [7:0] TARGET;
  logic [3:0] SCORE;
  logic [3:0] OPP_SCORE;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_v;
  wire  [20:0] obs = {STATE, TARGET, SCORE, OPP_SCORE, DONE};

  factor_game_ctrl #(
    .RESULT_CYC (R),
    .TICK_CYC   (TK),
    .ROUND_SEC  (RS),
    .WIN_SCORE  (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .OK        (OK),
    .NUM       (NUM),
    .KEY       (KEY),
    .OPP_DONE  (OPP_DONE),
    .STATE     (STATE),
    .TARGET    (TARGET),
    .SCORE     (SCORE),
    .OPP_SCORE (OPP_SCORE),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  // {STATE, TARGET, SCORE, OPP_SCORE, DONE}
  function automatic logic [20:0] ev(state_e s, logic [7:0] t, logic [3:0] sc,
                                     logic [3:0] op, logic d);
    return {4'(s), t, sc, op, d};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [3:0] n);
    OK = 1'b1; NUM = n;
    tick();
    OK = 1'b0; NUM = 4'd0;
  endtask

  task automatic press(input logic [3:0] k, input logic od);
    KEY = k; OPP_DONE = od;
    tick();
    KEY = 4'd0; OPP_DONE = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_good_round();
    start(4'd4);
    exp_v = ev(ST_PLAY, 8'd30, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL good_load: got %h want %h", obs, exp_v); end
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_PLAY, 8'd15, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL good_k2: got %h want %h", obs, exp_v); end
    press(KEY_P3, 1'b0);
    exp_v = ev(ST_PLAY, 8'd5, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL good_k3: got %h want %h", obs, exp_v); end
    press(KEY_P5, 1'b0);
    exp_v = ev(ST_GOOD, 8'd1, 4'd1, 4'd0, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL good_finish: got %h want %h", obs, exp_v); end
    for (int i = 0; i < R - 1; i++) begin
      tick();
      exp_v = ev(ST_GOOD, 8'd1, 4'd1, 4'd0, 1'b0); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL good_hold%0d: got %h want %h", i, obs, exp_v); end
    end
    tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL good_to_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_wrong_key();
    start(4'd1);
    exp_v = ev(ST_PLAY, 8'd12, 4'd1, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ouch_load: got %h want %h", obs, exp_v); end
    press(KEY_P5, 1'b0);
    exp_v = ev(ST_OUCH, 8'd12, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ouch_key5: got %h want %h", obs, exp_v); end
    // inputs during a result state must be ignored
    OK = 1'b1; NUM = 4'd4; KEY = KEY_P2; OPP_DONE = 1'b1;
    tick();
    OK = 1'b0; NUM = 4'd0; KEY = 4'd0; OPP_DONE = 1'b0;
    exp_v = ev(ST_OUCH, 8'd12, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ouch_ignore: got %h want %h", obs, exp_v); end
    repeat (R - 2) tick();
    exp_v = ev(ST_OUCH, 8'd12, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ouch_last: got %h want %h", obs, exp_v); end
    tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ouch_to_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_draw();
    start(4'd3);
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_PLAY, 8'd10, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL draw_k2a: got %h want %h", obs, exp_v); end
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_PLAY, 8'd5, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL draw_k2b: got %h want %h", obs, exp_v); end
    press(KEY_P5, 1'b1);
    exp_v = ev(ST_DRAW, 8'd1, 4'd1, 4'd1, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL draw_finish: got %h want %h", obs, exp_v); end
    tick();
    exp_v = ev(ST_DRAW, 8'd1, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL draw_done_pulse: got %h want %h", obs, exp_v); end
    repeat (R - 1) tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL draw_to_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_invalid();
    start(4'd0);
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL num0: got %h want %h", obs, exp_v); end
    start(4'd12);
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL num12: got %h want %h", obs, exp_v); end
    start(4'd2);
    exp_v = ev(ST_PLAY, 8'd18, 4'd1, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL num2_load: got %h want %h", obs, exp_v); end
    press(4'b0011, 1'b0);
    exp_v = ev(ST_OUCH, 8'd18, 4'd1, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL multihot: got %h want %h", obs, exp_v); end
    repeat (R - 1) tick();
    exp_v = ev(ST_OUCH, 8'd18, 4'd1, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL multihot_last: got %h want %h", obs, exp_v); end
    tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd1, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL multihot_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back_win();
    start(4'd1);
    press(KEY_P2, 1'b0);
    press(KEY_P3, 1'b0);
    exp_v = ev(ST_PLAY, 8'd2, 4'd1, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r2_mid: got %h want %h", obs, exp_v); end
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_GOOD, 8'd1, 4'd2, 4'd2, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r2_good: got %h want %h", obs, exp_v); end
    repeat (R) tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd2, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r2_idle: got %h want %h", obs, exp_v); end
    start(4'd10);
    exp_v = ev(ST_PLAY, 8'd210, 4'd2, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r3_load: got %h want %h", obs, exp_v); end
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_PLAY, 8'd105, 4'd2, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_2: got %h want %h", obs, exp_v); end
    press(KEY_P3, 1'b0);
    exp_v = ev(ST_PLAY, 8'd35, 4'd2, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_3: got %h want %h", obs, exp_v); end
    press(KEY_P5, 1'b0);
    exp_v = ev(ST_PLAY, 8'd7, 4'd2, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_5: got %h want %h", obs, exp_v); end
    press(KEY_P7, 1'b0);
    exp_v = ev(ST_GOOD, 8'd1, 4'd3, 4'd2, 1'b1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_7: got %h want %h", obs, exp_v); end
    repeat (R - 1) tick();
    exp_v = ev(ST_GOOD, 8'd1, 4'd3, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL r3_last: got %h want %h", obs, exp_v); end
    tick();
    exp_v = ev(ST_WIN, 8'd1, 4'd3, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL win: got %h want %h", obs, exp_v); end
    start(4'd4);
    press(KEY_P2, 1'b1);
    repeat (20) tick();
    exp_v = ev(ST_WIN, 8'd1, 4'd3, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL win_hold: got %h want %h", obs, exp_v); end
    RST = 1'b1; tick(); RST = 1'b0;
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL win_rst: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_lose();
    start(4'd5);
    press(4'd0, 1'b1);
    exp_v = ev(ST_OUCH, 8'd42, 4'd0, 4'd1, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL opp_done: got %h want %h", obs, exp_v); end
    repeat (R) tick();
    start(4'd5);
    press(KEY_P5, 1'b1);
    exp_v = ev(ST_OUCH, 8'd42, 4'd0, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrong_plus_opp: got %h want %h", obs, exp_v); end
    repeat (R) tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd2, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lose_mid_idle: got %h want %h", obs, exp_v); end
    start(4'd8);
    press(4'd0, 1'b1);
    exp_v = ev(ST_OUCH, 8'd90, 4'd0, 4'd3, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL opp_third: got %h want %h", obs, exp_v); end
    repeat (R) tick();
    exp_v = ev(ST_LOSE, 8'd90, 4'd0, 4'd3, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lose: got %h want %h", obs, exp_v); end
    RST = 1'b1; tick(); RST = 1'b0;
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL lose_rst: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    start(4'd6);
`ifdef FACTOR_GAME_TIMEOUT_EN
    for (int i = 0; i < TK * RS - 1; i++) begin
      tick();
      exp_v = ev(ST_PLAY, 8'd60, 4'd0, 4'd0, 1'b0); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tmo_play%0d: got %h want %h", i, obs, exp_v); end
    end
    tick();
    exp_v = ev(ST_DRAW, 8'd60, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_draw: got %h want %h", obs, exp_v); end
    repeat (R) tick();
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_idle: got %h want %h", obs, exp_v); end
`else
    repeat (3 * TK * RS) tick();
    exp_v = ev(ST_PLAY, 8'd60, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL no_timeout: got %h want %h", obs, exp_v); end
    RST = 1'b1; tick(); RST = 1'b0;
`endif
  endtask

  task automatic test_rst_mid_play();
    start(4'd7);
    press(KEY_P2, 1'b0);
    exp_v = ev(ST_PLAY, 8'd42, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_pre: got %h want %h", obs, exp_v); end
    RST = 1'b1; tick(); RST = 1'b0;
    exp_v = ev(ST_IDLE, 8'd0, 4'd0, 4'd0, 1'b0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_play: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_good_round();
    test_wrong_key();
    test_draw();
    test_invalid();
    test_back_to_back_win();
    test_lose();
    test_timeout();
    test_rst_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
